// File: rtl/serial_paralelo.sv
// serial_paralelo: serial-to-parallel converter with COM-symbol byte alignment.
//   clk_32f                 in   serial bit clock, all state advances on its rising edge
//   reset                   in   asynchronous active-high reset
//   data_in                 in   serial bit stream, MSB of each byte first
//   data_serial_paralelo    out  recovered byte (8'h00 until aligned)
//   valid_serial_paralelo   out  recovered byte is payload, not COM_SYMBOL
//   active_serial_paralelo  out  link aligned (only with SERPAR_STATUS_EN defined)
// Optional feature macro: SERPAR_STATUS_EN
module serial_paralelo #(
    parameter logic [7:0] COM_SYMBOL = 8'hBC,
    parameter int         COM_LOCK   = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_serial_paralelo,
`ifdef SERPAR_STATUS_EN
    output logic       active_serial_paralelo,
`endif
    output logic       valid_serial_paralelo
);
    localparam logic [3:0] LOCK = 4'(COM_LOCK);

    typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;

    state_t     state, state_nx;
    logic [7:0] shreg, next_byte, data_nx;
    logic [2:0] bit_cnt, bit_cnt_nx;
    logic [3:0] com_cnt, com_cnt_nx;
    logic       valid_nx, is_com, boundary;

    assign next_byte = {shreg[6:0], data_in};
    assign is_com    = next_byte == COM_SYMBOL;
    assign boundary  = bit_cnt == 3'd7;

    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt + 3'd1;
        com_cnt_nx = com_cnt;
        data_nx    = (state == ACTIVE) ? data_serial_paralelo : 8'h00;
        valid_nx   = (state == ACTIVE) ? valid_serial_paralelo : 1'b0;
        case (state)
            SEARCH: begin
                // Bit-level hunt: the counter is held so the first COM sets the byte phase.
                bit_cnt_nx = 3'd0;
                state_nx   = is_com ? ALIGN : SEARCH;
                com_cnt_nx = is_com ? 4'd1 : 4'd0;
            end
            ALIGN: if (boundary) begin
                com_cnt_nx = is_com ? com_cnt + 4'd1 : 4'd0;
                // The locking COM itself is not published; output starts next byte.
                state_nx   = !is_com ? SEARCH : (com_cnt + 4'd1 == LOCK) ? ACTIVE : ALIGN;
            end
            ACTIVE: if (boundary) begin
                data_nx  = next_byte;
                valid_nx = !is_com;
            end
            default: state_nx = SEARCH;
        endcase
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state                 <= SEARCH;
            shreg                 <= 8'h00;
            bit_cnt               <= 3'd0;
            com_cnt               <= 4'd0;
            data_serial_paralelo  <= 8'h00;
            valid_serial_paralelo <= 1'b0;
        end else begin
            state                 <= state_nx;
            shreg                 <= next_byte;
            bit_cnt               <= bit_cnt_nx;
            com_cnt               <= com_cnt_nx;
            data_serial_paralelo  <= data_nx;
            valid_serial_paralelo <= valid_nx;
        end
    end

`ifdef SERPAR_STATUS_EN
    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) active_serial_paralelo <= 1'b0;
        else       active_serial_paralelo <= state_nx == ACTIVE;
    end
`endif
endmodule

// File: tb/tb_serial_paralelo.sv
// tb_serial_paralelo: table-driven, scoreboarded bench for serial_paralelo.
//   Drives bytes MSB first, samples outputs 1 time unit after each rising edge.
//   Build with SERPAR_STATUS_EN defined to also check active_serial_paralelo.
module tb_serial_paralelo;
    logic       clk_32f = 1'b0;
    logic       reset   = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_serial_paralelo;
    logic       valid_serial_paralelo;
`ifdef SERPAR_STATUS_EN
    logic       active_serial_paralelo;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] cur_d = 8'h00;
    logic       cur_v = 1'b0;

    typedef struct {
        logic [7:0] b;
        logic [7:0] d;
        logic       v;
        logic       a;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       a;
    } out_t;

    vec_t tbl[11];
    out_t sb[$];

    serial_paralelo dut (
        .clk_32f               (clk_32f),
        .reset                 (reset),
        .data_in               (data_in),
        .data_serial_paralelo  (data_serial_paralelo),
`ifdef SERPAR_STATUS_EN
        .active_serial_paralelo(active_serial_paralelo),
`endif
        .valid_serial_paralelo (valid_serial_paralelo)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Send one byte; expected outputs after its LSB edge are queued when the LSB is driven.
    task automatic send_byte(input logic [7:0] b, input logic [7:0] d, input logic v,
                             input logic a, input string nm);
        out_t e;
        for (int i = 7; i >= 0; i--) begin
            data_in = b[i];
            if (i == 0) sb.push_back('{d, v, a});
            @(posedge clk_32f);
            #1;
            if (i != 0) begin
                chk({nm, " hold data"}, data_serial_paralelo, cur_d);
                chk({nm, " hold valid"}, {7'd0, valid_serial_paralelo}, {7'd0, cur_v});
            end
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, " data"}, data_serial_paralelo, e.d);
            chk({nm, " valid"}, {7'd0, valid_serial_paralelo}, {7'd0, e.v});
`ifdef SERPAR_STATUS_EN
            chk({nm, " active"}, {7'd0, active_serial_paralelo}, {7'd0, e.a});
`endif
            cur_d = e.d;
            cur_v = e.v;
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            data_in = b[i];
            @(posedge clk_32f);
            #1;
        end
    endtask

    // Asserts reset between edges and checks the outputs clear before any clock edge.
    task automatic do_reset(input string nm);
        reset = 1'b1;
        #2;
        chk({nm, " async data"}, data_serial_paralelo, 8'h00);
        chk({nm, " async valid"}, {7'd0, valid_serial_paralelo}, 8'h00);
`ifdef SERPAR_STATUS_EN
        chk({nm, " async active"}, {7'd0, active_serial_paralelo}, 8'h00);
`endif
        @(posedge clk_32f);
        #1;
        reset = 1'b0;
        cur_d = 8'h00;
        cur_v = 1'b0;
        sb.delete();
    endtask

    initial begin
        tbl = '{
            '{8'hBC, 8'h00, 1'b0, 1'b0},
            '{8'hBC, 8'h00, 1'b0, 1'b0},
            '{8'hBC, 8'h00, 1'b0, 1'b0},
            '{8'hBC, 8'h00, 1'b0, 1'b1},
            '{8'hA5, 8'hA5, 1'b1, 1'b1},
            '{8'h3C, 8'h3C, 1'b1, 1'b1},
            '{8'h01, 8'h01, 1'b1, 1'b1},
            '{8'hBC, 8'hBC, 1'b0, 1'b1},
            '{8'h02, 8'h02, 1'b1, 1'b1},
            '{8'h00, 8'h00, 1'b1, 1'b1},
            '{8'h00, 8'h00, 1'b1, 1'b1}
        };

        @(posedge clk_32f);
        #1;
        do_reset("initial reset");

        // Three junk bits (010) so the first COM lands off any byte phase.
        send_bits(8'h40, 3);
        for (int i = 0; i < 11; i++)
            send_byte(tbl[i].b, tbl[i].d, tbl[i].v, tbl[i].a, $sformatf("row%0d", i));

        // Reset in ACTIVE mid-byte, then full re-lock.
        send_bits(8'hFF, 4);
        do_reset("active reset");
        for (int i = 0; i < 4; i++)
            send_byte(8'hBC, 8'h00, 1'b0, i == 3, $sformatf("relock com%0d", i));
        send_byte(8'h5A, 8'h5A, 1'b1, 1'b1, "relock 5A");

        // Three COMs then a non-COM byte: back to SEARCH, no output.
        do_reset("seq29 reset");
        for (int i = 0; i < 3; i++)
            send_byte(8'hBC, 8'h00, 1'b0, 1'b0, $sformatf("short com%0d", i));
        send_byte(8'h11, 8'h00, 1'b0, 1'b0, "short 11");
        for (int i = 0; i < 4; i++)
            send_byte(8'hBC, 8'h00, 1'b0, i == 3, $sformatf("lock com%0d", i));
        send_byte(8'h22, 8'h22, 1'b1, 1'b1, "lock 22");

        // Reset in ALIGN mid-byte must discard the COMs counted before it.
        do_reset("seq23 reset");
        send_byte(8'hBC, 8'h00, 1'b0, 1'b0, "pre com0");
        send_byte(8'hBC, 8'h00, 1'b0, 1'b0, "pre com1");
        send_bits(8'hBC, 4);
        do_reset("align reset");
        for (int i = 0; i < 3; i++)
            send_byte(8'hBC, 8'h00, 1'b0, 1'b0, $sformatf("post com%0d", i));
        send_byte(8'h77, 8'h00, 1'b0, 1'b0, "post 77");
        for (int i = 0; i < 4; i++)
            send_byte(8'hBC, 8'h00, 1'b0, i == 3, $sformatf("final com%0d", i));
        send_byte(8'h66, 8'h66, 1'b1, 1'b1, "final 66");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_paralelo.md
SERIAL_PARALELO -- requirements
Module: serial_paralelo

Interface
REQ-001 Parameter COM_SYMBOL, default 8'hBC, alignment/idle symbol.
REQ-002 Parameter COM_LOCK, default 4, number of consecutive COM_SYMBOL bytes needed to declare alignment (legal range 2..15).
REQ-003 clk_32f  input  1  serial bit clock; all state advances on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 data_in  input  1  serial bit stream, MSB of each byte first, one bit per clk_32f cycle.
REQ-006 data_serial_paralelo  output  8  recovered byte, registered.
REQ-007 valid_serial_paralelo  output  1  recovered byte is payload (not COM_SYMBOL), registered.
REQ-008 active_serial_paralelo  output  1  link aligned; present only under SERPAR_STATUS_EN.

Function
REQ-009 Shift register shreg SHALL load {shreg[6:0], data_in} on every clk_32f edge; "next byte" means this value.
REQ-010 FSM SHALL have exactly three states: SEARCH, ALIGN, ACTIVE; reset state SEARCH.
REQ-011 SEARCH: bit-level hunt; on the edge where next byte == COM_SYMBOL -> ALIGN, com_cnt=1, bit_cnt=0; otherwise stay, com_cnt=0.
REQ-012 bit_cnt (3 bits) SHALL increment every edge outside SEARCH, wrapping 7->0; byte boundary = edge with bit_cnt==7.
REQ-013 ALIGN: at a byte boundary, next byte == COM_SYMBOL -> com_cnt+1; com_cnt reaching COM_LOCK -> ACTIVE.
REQ-014 ALIGN: at a byte boundary, next byte != COM_SYMBOL -> SEARCH, com_cnt=0, no output change.
REQ-015 ACTIVE SHALL persist until reset; no loss-of-lock exit.
REQ-016 ACTIVE: at each byte boundary data_serial_paralelo <= next byte and valid_serial_paralelo <= (next byte != COM_SYMBOL).
REQ-017 Latency: outputs update on the same edge that samples the byte's last (LSB) bit; zero extra pipeline stages.
REQ-018 Outputs SHALL hold for the full 8-cycle byte period between boundaries.
REQ-019 Byte that completes the lock (COM_LOCK-th COM) SHALL NOT update outputs; first output update is the next boundary in ACTIVE.
REQ-020 Outside ACTIVE: data_serial_paralelo = 8'h00, valid_serial_paralelo = 0.
REQ-021 COM_SYMBOL arriving in ACTIVE SHALL be published as data with valid=0 (idle indication to demux_8_32).

Reset
REQ-022 reset high SHALL immediately, without a clock edge, force: state=SEARCH, shreg=0, bit_cnt=0, com_cnt=0, data_serial_paralelo=8'h00, valid_serial_paralelo=0, active_serial_paralelo=0.
REQ-023 Reset asserted mid-byte or in ACTIVE SHALL discard all alignment; full re-lock required after release.
REQ-024 First edge after reset release SHALL shift data_in normally.

Configuration
REQ-025 Macro SERPAR_STATUS_EN defined: port active_serial_paralelo exists, registered, 1 exactly while state==ACTIVE (set on the lock edge).
REQ-026 Macro SERPAR_STATUS_EN undefined: port absent, all other behaviour bit- and cycle-identical.

Verification
REQ-027 Reset pulse mid-stream in ACTIVE -> outputs 0 and state SEARCH asynchronously; 4x 8'hBC after release -> re-lock.
REQ-028 Three junk bits, then 4x 8'hBC, then 8'hA5, 8'h3C -> data 8'hA5 valid=1 on A5's LSB edge, 8'h3C valid=1 eight cycles later.
REQ-029 3x 8'hBC then 8'h11 -> return to SEARCH, outputs stay 8'h00/valid 0; a following 4x 8'hBC then 8'h22 -> 8'h22 valid=1.
REQ-030 Locked stream 8'h01, 8'hBC, 8'h02 -> valid 1,0,1, with data 8'hBC during the middle period.
REQ-031 Locked stream of 8'h00 bytes -> data 8'h00 with valid=1 (payload zero distinguished from idle).
REQ-032 With SERPAR_STATUS_EN: active_serial_paralelo rises on the edge of the 4th COM's LSB, falls on reset.
